imgproc_msg_poller: RTL
=======================

# imgproc_msg_poller

- Autonomous Avalon-MM master that drains the image processor's bounding-box message FIFO through its memory-mapped slave port.
- Periodically polls the status register and reads queued message words. It parses 3-word "RBB" messages and presents the latest bounding box as registered outputs with a valid strobe.
- Sits between the image processor's mm slave and downstream steering/control logic, so the CPU no longer needs to service the FIFO.

## Interface

Parameters:
- POLL_INTERVAL, 1024: idle cycles between status polls (≥1).
- MSG_ID, 32'h0052_4242: expected header word ("RBB", zero-extended).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: polling allowed when high.
- flush_req, input, 1: single-cycle request to flush the processor FIFO.
- m_chipselect, output, 1: slave chipselect.
- m_read, output, 1: slave read strobe.
- m_write, output, 1: slave write strobe.
- m_address, output, 3: slave address (0 = status, 1 = message).
- m_writedata, output, 32: slave write data.
- m_readdata, input, 32: slave read data, valid the cycle after m_read.
- bb_valid, output, 1: one-cycle pulse when new box fields are presented.
- bb_x_min, bb_y_min, bb_x_max, bb_y_max, output, 11 each: latest box corners.
- bb_col, output, 1: colour flag from the top-left word, bit 31.
- sync_err, output, 8: saturating count of discarded non-header words.
- busy, output, 1: high in any state other than IDLE.

## Operation

- FSM states: IDLE, ST_RD, ST_CAP, MSG_RD, MSG_CAP, FLUSH, PRESENT.
- **IDLE**
  - The poll timer counts down from POLL_INTERVAL-1 while enable=1. While enable=0 it is held at reload.
  - If a flush is pending → FLUSH (flush takes priority over the poll).
  - Else, when timer=0 and enable=1 → ST_RD.
- **ST_RD** (1 cycle): drive m_chipselect=1, m_read=1, m_address=0 → ST_CAP.
- **ST_CAP**
  - m_read=0; capture remain = m_readdata[15:8].
  - If remain ≥ 3 → MSG_RD with idx=0.
  - Else → IDLE with the timer reloaded.
- **MSG_RD** (1 cycle): drive m_chipselect=1, m_read=1, m_address=1 → MSG_CAP.
- **MSG_CAP**
  - m_read=0; capture the word and set remain = remain-1.
  - idx=0:
    - If word == MSG_ID → idx=1.
    - Else sync_err increments (saturates at 255) and idx stays 0.
  - idx=1: shadow x_min=[26:16], y_min=[10:0], col=[31] → idx=2.
  - idx=2: shadow x_max=[26:16], y_max=[10:0] → PRESENT.
  - For idx 0 and 1, after the capture:
    - If remain=0, or (idx=0 and remain<3) → IDLE.
    - Else → MSG_RD.
- **PRESENT** (1 cycle)
  - Copy all shadow fields to the bb_* outputs in the same edge and pulse bb_valid.
  - If remain ≥ 3 → MSG_RD with idx=0; else → IDLE.
- **FLUSH** (1 cycle)
  - Drive m_chipselect=1, m_write=1, m_address=0, m_writedata=32'h10.
  - Clear the pending flag and idx → IDLE with the timer reloaded.
- flush_req arriving outside IDLE sets a pending flag. It is serviced on the next IDLE cycle and aborts no transfer in progress.
- Partial messages never update the outputs. A header not followed by a complete message is not presented.
- m_writedata is 0 except in FLUSH. m_write is never asserted together with m_read.

## Timing

- Reset values:
  - All m_* outputs, bb_*, bb_valid, sync_err and busy are 0.
  - State=IDLE, timer=POLL_INTERVAL-1, pending flush cleared.
- Reset asserted mid-transfer: the strobes drop at the next edge and no partial box is presented.
- m_read is high for exactly one cycle and is always followed by at least one low cycle. This is required because the slave pops its FIFO on the read rising edge.
- Each word costs 2 cycles (RD + CAP).
- A full message from poll start takes 10 cycles: status 2, words 6, PRESENT 1, return to IDLE 1. bb_valid is asserted in cycle 9.
- Outputs are registered; bb_* hold their values until the next PRESENT.
- The first poll occurs POLL_INTERVAL cycles after reset release with enable=1.

## Test plan

- **Single message.** Slave model holds 3 words: 0x00524242, 0x8012_0034, 0x0150_00C8.
  - Required: bb_valid pulses once with x_min=0x012, y_min=0x034, col=1, x_max=0x150, y_max=0x0C8.
  - Exactly 4 read pulses (1 status + 3 message), each separated by a low cycle.
- **Empty or short FIFO.** Status reports words=2.
  - Required: one status read only, no message reads, no bb_valid, return to IDLE.
- **Resync.** FIFO holds 0xDEADBEEF followed by a valid 3-word message (words=4).
  - Required: sync_err=1 and one bb_valid with the correct box.
- **Two messages back to back.** FIFO holds 6 words (two valid messages).
  - Required: two bb_valid pulses 7 cycles apart; the outputs show the second box at the end.
- **Flush during a transfer.** flush_req is pulsed while in MSG_RD.
  - Required: the current message completes, then one write cycle with address 0 and data 0x10, then IDLE.
- **Reset and enable.** Reset is asserted in MSG_CAP with idx=1.
  - Required: all outputs return to 0 next cycle and bb_valid never fires.
  - With enable=0: no bus activity for 3×POLL_INTERVAL cycles.

Source files
------------

// File: rtl/imgproc_msg_poller.sv
// imgproc_msg_poller: autonomous Avalon-MM master that polls the image
// processor's message FIFO, parses 3-word "RBB" bounding-box messages and
// presents the most recent complete box on registered outputs.
module imgproc_msg_poller #(
    parameter int unsigned POLL_INTERVAL = 1024,
    parameter logic [31:0] MSG_ID        = 32'h0052_4242
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        flush_req,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        bb_valid,
    output logic [10:0] bb_x_min,
    output logic [10:0] bb_y_min,
    output logic [10:0] bb_x_max,
    output logic [10:0] bb_y_max,
    output logic        bb_col,
    output logic [7:0]  sync_err,
    output logic        busy
);

    localparam int unsigned TIMER_W = (POLL_INTERVAL > 32'd1) ? $clog2(POLL_INTERVAL) : 32'd1;
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_INTERVAL - 32'd1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO   = TIMER_W'(32'd0);
    localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(32'd1);

    localparam logic [2:0]  ADDR_STATUS = 3'd0;
    localparam logic [2:0]  ADDR_MSG    = 3'd1;
    localparam logic [31:0] FLUSH_CMD   = 32'h0000_0010;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        MSG_RD  = 3'd3,
        MSG_CAP = 3'd4,
        FLUSH   = 3'd5,
        PRESENT = 3'd6
    } state_t;

    // Saturating 8-bit increment for the resync error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

    // True when a captured word is the message header.
    function automatic logic is_header(input logic [31:0] word);
        return (word == MSG_ID);
    endfunction

    state_t               state_r;
    state_t               state_next_s;
    logic [TIMER_W-1:0]   timer_r;
    logic [TIMER_W-1:0]   timer_next_s;
    logic [7:0]           remain_r;
    logic [7:0]           remain_next_s;
    logic [7:0]           remain_dec_s;
    logic [1:0]           idx_r;
    logic [1:0]           idx_next_s;
    logic                 flush_pend_r;
    logic                 flush_pend_next_s;
    logic [7:0]           sync_err_r;
    logic [7:0]           sync_err_next_s;
    logic [10:0]          sh_x_min_r;
    logic [10:0]          sh_x_min_next_s;
    logic [10:0]          sh_y_min_r;
    logic [10:0]          sh_y_min_next_s;
    logic                 sh_col_r;
    logic                 sh_col_next_s;
    logic                 load_box_s;

    logic                 m_chipselect_r;
    logic                 m_read_r;
    logic                 m_write_r;
    logic [2:0]           m_address_r;
    logic [31:0]          m_writedata_r;
    logic                 bb_valid_r;
    logic [10:0]          bb_x_min_r;
    logic [10:0]          bb_y_min_r;
    logic [10:0]          bb_x_max_r;
    logic [10:0]          bb_y_max_r;
    logic                 bb_col_r;
    logic                 busy_r;

    // Remaining-word count minus one, clamped so it can never wrap.
    always_comb begin
        if (remain_r != 8'd0) begin
            remain_dec_s = remain_r - 8'd1;
        end else begin
            remain_dec_s = 8'd0;
        end
    end

    // Next-state, poll timer, message parser and shadow-field logic.
    always_comb begin
        state_next_s      = state_r;
        timer_next_s      = TIMER_RELOAD;
        remain_next_s     = remain_r;
        idx_next_s        = idx_r;
        flush_pend_next_s = flush_pend_r | flush_req;
        sync_err_next_s   = sync_err_r;
        sh_x_min_next_s   = sh_x_min_r;
        sh_y_min_next_s   = sh_y_min_r;
        sh_col_next_s     = sh_col_r;
        load_box_s        = 1'b0;

        case (state_r)
            IDLE: begin
                if (flush_pend_r || flush_req) begin
                    // Flush wins over a poll that is due in the same cycle.
                    state_next_s = FLUSH;
                    timer_next_s = TIMER_RELOAD;
                end else if (!enable) begin
                    timer_next_s = TIMER_RELOAD;
                end else if (timer_r == TIMER_ZERO) begin
                    state_next_s = ST_RD;
                    timer_next_s = TIMER_RELOAD;
                end else begin
                    timer_next_s = timer_r - TIMER_ONE;
                end
            end

            ST_RD: begin
                state_next_s = ST_CAP;
            end

            ST_CAP: begin
                remain_next_s = m_readdata[15:8];
                idx_next_s    = 2'd0;
                if (m_readdata[15:8] >= 8'd3) begin
                    state_next_s = MSG_RD;
                end else begin
                    state_next_s = IDLE;
                end
            end

            MSG_RD: begin
                state_next_s = MSG_CAP;
            end

            MSG_CAP: begin
                remain_next_s = remain_dec_s;
                case (idx_r)
                    2'd0: begin
                        if (is_header(m_readdata)) begin
                            // Header found: two more words complete the box.
                            if (remain_dec_s == 8'd0) begin
                                idx_next_s   = 2'd0;
                                state_next_s = IDLE;
                            end else begin
                                idx_next_s   = 2'd1;
                                state_next_s = MSG_RD;
                            end
                        end else begin
                            // Not a header: discard it and keep hunting only
                            // while a whole message could still follow.
                            sync_err_next_s = sat_inc8(sync_err_r);
                            idx_next_s      = 2'd0;
                            if (remain_dec_s < 8'd3) begin
                                state_next_s = IDLE;
                            end else begin
                                state_next_s = MSG_RD;
                            end
                        end
                    end
                    2'd1: begin
                        sh_x_min_next_s = m_readdata[26:16];
                        sh_y_min_next_s = m_readdata[10:0];
                        sh_col_next_s   = m_readdata[31];
                        if (remain_dec_s == 8'd0) begin
                            idx_next_s   = 2'd0;
                            state_next_s = IDLE;
                        end else begin
                            idx_next_s   = 2'd2;
                            state_next_s = MSG_RD;
                        end
                    end
                    2'd2: begin
                        // Last word: the box is loaded on this edge so that
                        // bb_valid is visible during the PRESENT cycle.
                        load_box_s   = 1'b1;
                        idx_next_s   = 2'd0;
                        state_next_s = PRESENT;
                    end
                    default: begin
                        idx_next_s   = 2'd0;
                        state_next_s = IDLE;
                    end
                endcase
            end

            PRESENT: begin
                idx_next_s = 2'd0;
                if (remain_r >= 8'd3) begin
                    state_next_s = MSG_RD;
                end else begin
                    state_next_s = IDLE;
                end
            end

            FLUSH: begin
                flush_pend_next_s = 1'b0;
                idx_next_s        = 2'd0;
                state_next_s      = IDLE;
            end

            default: begin
                idx_next_s   = 2'd0;
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state and parser bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            timer_r      <= TIMER_RELOAD;
            remain_r     <= 8'd0;
            idx_r        <= 2'd0;
            flush_pend_r <= 1'b0;
            sync_err_r   <= 8'd0;
            sh_x_min_r   <= 11'd0;
            sh_y_min_r   <= 11'd0;
            sh_col_r     <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            timer_r      <= timer_next_s;
            remain_r     <= remain_next_s;
            idx_r        <= idx_next_s;
            flush_pend_r <= flush_pend_next_s;
            sync_err_r   <= sync_err_next_s;
            sh_x_min_r   <= sh_x_min_next_s;
            sh_y_min_r   <= sh_y_min_next_s;
            sh_col_r     <= sh_col_next_s;
        end
    end

    // Bus strobes and busy are registered from the next state so they line
    // up exactly with the RD/FLUSH cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_chipselect_r <= 1'b0;
            m_read_r       <= 1'b0;
            m_write_r      <= 1'b0;
            m_address_r    <= 3'd0;
            m_writedata_r  <= 32'd0;
            busy_r         <= 1'b0;
        end else begin
            m_chipselect_r <= (state_next_s == ST_RD) || (state_next_s == MSG_RD) ||
                              (state_next_s == FLUSH);
            m_read_r       <= (state_next_s == ST_RD) || (state_next_s == MSG_RD);
            m_write_r      <= (state_next_s == FLUSH);
            m_address_r    <= (state_next_s == MSG_RD) ? ADDR_MSG : ADDR_STATUS;
            m_writedata_r  <= (state_next_s == FLUSH) ? FLUSH_CMD : 32'd0;
            busy_r         <= (state_next_s != IDLE);
        end
    end

    // Presented box: updated only when a complete message has been parsed.
    always_ff @(posedge clk) begin
        if (reset) begin
            bb_valid_r <= 1'b0;
            bb_x_min_r <= 11'd0;
            bb_y_min_r <= 11'd0;
            bb_x_max_r <= 11'd0;
            bb_y_max_r <= 11'd0;
            bb_col_r   <= 1'b0;
        end else begin
            bb_valid_r <= load_box_s;
            if (load_box_s) begin
                bb_x_min_r <= sh_x_min_r;
                bb_y_min_r <= sh_y_min_r;
                bb_col_r   <= sh_col_r;
                bb_x_max_r <= m_readdata[26:16];
                bb_y_max_r <= m_readdata[10:0];
            end
        end
    end

    assign m_chipselect = m_chipselect_r;
    assign m_read       = m_read_r;
    assign m_write      = m_write_r;
    assign m_address    = m_address_r;
    assign m_writedata  = m_writedata_r;
    assign bb_valid     = bb_valid_r;
    assign bb_x_min     = bb_x_min_r;
    assign bb_y_min     = bb_y_min_r;
    assign bb_x_max     = bb_x_max_r;
    assign bb_y_max     = bb_y_max_r;
    assign bb_col       = bb_col_r;
    assign sync_err     = sync_err_r;
    assign busy         = busy_r;

endmodule
